// File: rtl/speed_pkg.sv
// Shared types and word-packing helper for the encoder speed sampler.
package speed_pkg;

  localparam int unsigned SPEED_MAG_W  = 24;
  localparam int unsigned SPEED_PAD_W  = 7;
  localparam int unsigned SPEED_WORD_W = SPEED_PAD_W + 1 + SPEED_MAG_W;
  localparam logic [SPEED_MAG_W-1:0] SPEED_MAG_MAX = '1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Sign-magnitude speed word: {pad, sign, magnitude}.
  function automatic logic [SPEED_WORD_W-1:0] pack_speed(input logic sign,
                                                         input logic [SPEED_MAG_W-1:0] mag);
    return {{SPEED_PAD_W{1'b0}}, sign, mag};
  endfunction

endpackage

// File: rtl/speed_abs_sat.sv
// Combinational count-delta to sign/magnitude converter with magnitude saturation.
module speed_abs_sat
  import speed_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic [CNT_W-1:0]       cur,
  input  logic [CNT_W-1:0]       prev,
  output logic                   sign,
  output logic [SPEED_MAG_W-1:0] mag,
  output logic                   sat
);

  localparam int unsigned EXT_W = (CNT_W > SPEED_MAG_W) ? CNT_W : SPEED_MAG_W;

  logic [CNT_W-1:0] delta;
  logic [CNT_W-1:0] abs_val;
  logic [EXT_W-1:0] abs_ext;

  // Modular subtraction makes encoder wrap produce the true small delta.
  assign delta   = cur - prev;
  assign sign    = delta[CNT_W-1];
  // The most negative delta negates to itself; its MSB still forces saturation.
  assign abs_val = sign ? ({CNT_W{1'b0}} - delta) : delta;
  assign abs_ext = EXT_W'(abs_val);
  assign sat     = |(abs_ext >> SPEED_MAG_W);
  assign mag     = sat ? SPEED_MAG_MAX : abs_ext[SPEED_MAG_W-1:0];

endmodule

// File: rtl/speed_sample_scheduler.sv
// Periodic encoder snapshot plus time-multiplexed speed calculation into a
// double-buffered, address-readable result bank.
module speed_sample_scheduler
  import speed_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PERIOD = 50000,
  localparam int unsigned AW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH*CNT_W-1:0] count_flat,
  input  logic [AW-1:0]         rd_addr,
  output logic [31:0]           rd_data,
  output logic [N_CH-1:0]       sat_flags,
  output logic                  sample_done,
  output logic                  busy
);

  localparam int unsigned TW = $clog2(PERIOD);

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q;
  logic [AW-1:0]           ch_q;
  logic                    primed_q;
  logic [CNT_W-1:0]        snap_q      [N_CH];
  logic [CNT_W-1:0]        prev_q      [N_CH];
  logic [31:0]             staging_q   [N_CH];
  logic [31:0]             published_q [N_CH];
  logic [N_CH-1:0]         stage_sat_q;
  logic [N_CH-1:0]         sat_flags_q;
  logic [31:0]             rd_data_q;
  logic                    sample_done_q;

  logic                    tick;
  logic                    last_ch;
  logic                    calc_sign;
  logic [SPEED_MAG_W-1:0]  calc_mag;
  logic                    calc_sat;
  logic [31:0]             calc_word;
  logic                    calc_flag;

  assign tick    = enable && (timer_q == TW'(PERIOD - 1));
  assign last_ch = (32'(ch_q) == N_CH - 1);

  speed_abs_sat #(
    .CNT_W (CNT_W)
  ) u_abs_sat (
    .cur  (snap_q[ch_q]),
    .prev (prev_q[ch_q]),
    .sign (calc_sign),
    .mag  (calc_mag),
    .sat  (calc_sat)
  );

  // The first snapshot after reset has no valid history, so it stages zeros.
  assign calc_word = primed_q ? pack_speed(calc_sign, calc_mag) : '0;
  assign calc_flag = primed_q & calc_sat;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = CALC;
      CALC:    if (last_ch) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      ch_q          <= '0;
      primed_q      <= 1'b0;
      stage_sat_q   <= '0;
      sat_flags_q   <= '0;
      rd_data_q     <= '0;
      sample_done_q <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        snap_q[k]      <= '0;
        prev_q[k]      <= '0;
        staging_q[k]   <= '0;
        published_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      timer_q       <= (!enable || tick) ? '0 : timer_q + TW'(1);
      sample_done_q <= (state_q == DONE);
      rd_data_q     <= (32'(rd_addr) < N_CH) ? published_q[rd_addr] : '0;
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            ch_q <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
              snap_q[k] <= count_flat[k*CNT_W +: CNT_W];
              prev_q[k] <= snap_q[k];
            end
          end
        end
        CALC: begin
          staging_q[ch_q]   <= calc_word;
          stage_sat_q[ch_q] <= calc_flag;
          if (!last_ch) ch_q <= ch_q + AW'(1);
        end
        DONE: begin
          for (int unsigned k = 0; k < N_CH; k++) published_q[k] <= staging_q[k];
          sat_flags_q <= stage_sat_q;
          primed_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_data     = rd_data_q;
  assign sat_flags   = sat_flags_q;
  assign sample_done = sample_done_q;
  assign busy        = (state_q != IDLE);

  // PERIOD >= N_CH+4 must keep ticks out of the busy window.
  tick_while_busy: assert property (@(posedge clock) disable iff (reset)
                                    !(tick && state_q != IDLE))
    else $error("sample tick arrived while a calculation was in flight");

endmodule

// File: tb/tb_speed_sample_scheduler.sv
// Scoreboard bench for speed_sample_scheduler: expected banks are queued as
// counts are driven and compared against the readout when sample_done fires.
module tb_speed_sample_scheduler;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned PERIOD = 16;
  localparam int unsigned AW     = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [N_CH*CNT_W-1:0] count_flat;
  logic [AW-1:0]         rd_addr;
  logic [31:0]           rd_data;
  logic [N_CH-1:0]       sat_flags;
  logic                  sample_done;
  logic                  busy;

  speed_sample_scheduler #(
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .PERIOD (PERIOD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .count_flat  (count_flat),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sat_flags   (sat_flags),
    .sample_done (sample_done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [N_CH-1:0][31:0] w;
    logic [N_CH-1:0]       sat;
  } bank_t;

  bank_t                 sb[$];
  logic [N_CH-1:0][31:0] m_prev;
  bit                    m_primed;
  int                    last_done;

  // Reference: 64-bit signed arithmetic on the modular delta.
  function automatic logic [32:0] model_word(input logic [31:0] cur, input logic [31:0] prv);
    logic [31:0]     d;
    longint          sd;
    longint          a;
    bit              s;
    logic [23:0]     mag;
    d   = cur - prv;
    sd  = longint'($signed(d));
    a   = (sd < 0) ? -sd : sd;
    s   = (a > 64'h0000_0000_00FF_FFFF);
    mag = s ? 24'hFF_FFFF : a[23:0];
    return {s, 7'b0, (sd < 0), mag};
  endfunction

  task automatic push_sample(input logic [31:0] c0, input logic [31:0] c1,
                             input logic [31:0] c2, input logic [31:0] c3);
    logic [N_CH-1:0][31:0] c;
    bank_t                 b;
    logic [32:0]           r;
    c          = {c3, c2, c1, c0};
    count_flat = c;
    b          = '0;
    if (m_primed) begin
      for (int k = 0; k < N_CH; k++) begin
        r        = model_word(c[k], m_prev[k]);
        b.w[k]   = r[31:0];
        b.sat[k] = r[32];
      end
    end
    m_primed = 1'b1;
    m_prev   = c;
    sb.push_back(b);
  endtask

  task automatic expect_sample(input string tag, input bit chk_space);
    bank_t b;
    bit    found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clock);
      if (sample_done) found = 1'b1;
    end
    if (!found || sb.size() == 0) begin
      check_eq({tag, "_done_seen"}, 32'(found), 32'(1));
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    b = sb.pop_front();
    if (chk_space) check_eq({tag, "_spacing"}, 32'(cyc - last_done), PERIOD);
    last_done = cyc;
    check_eq({tag, "_sat"}, 32'(sat_flags), 32'(b.sat));
    for (int k = 0; k < N_CH; k++) begin
      rd_addr = 2'(k);
      @(negedge clock);
      check_eq($sformatf("%s_rd%0d", tag, k), rd_data, b.w[k]);
    end
  endtask

  task automatic wait_busy(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clock);
      if (busy) seen = 1'b1;
    end
    if (!seen) check_eq({tag, "_busy_seen"}, 32'(seen), 32'(1));
  endtask

  // Each busy window must span N_CH CALC cycles plus the DONE cycle.
  int busy_run = 0;
  always @(negedge clock) begin
    if (reset) busy_run = 0;
    else if (busy) busy_run++;
    else if (busy_run != 0) begin
      check_eq("busy_len", 32'(busy_run), N_CH + 1);
      busy_run = 0;
    end
  end

  initial begin
    int n_done;
    int c0;
    reset      = 1'b1;
    enable     = 1'b0;
    rd_addr    = '0;
    m_primed   = 1'b0;
    m_prev     = '0;
    last_done  = 0;
    count_flat = {$urandom(), $urandom(), $urandom(), $urandom()};

    repeat (5) @(negedge clock);
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_sat", 32'(sat_flags), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(sample_done), 32'h0);

    @(posedge clock);
    #1;
    reset  = 1'b0;
    enable = 1'b1;

    push_sample(32'd100, 32'd1000, 32'd777, 32'h0000_0000);
    expect_sample("prime", 1'b0);
    push_sample(32'd350, 32'd400, 32'd777, 32'hFF00_0000);
    expect_sample("basic", 1'b1);
    push_sample(32'h7FFF_FFF0, 32'hFFFF_FFFE, 32'd777, 32'hFF00_0005);
    expect_sample("small", 1'b1);
    push_sample(32'h8000_0010, 32'h0000_0003, 32'd777, 32'h0000_0005);
    expect_sample("wrap1", 1'b1);
    push_sample(32'h0000_0020, 32'h0000_0005, 32'd777 + 32'h8000_0000, 32'h0000_0005);
    expect_sample("wrap2", 1'b1);

    // Abort a sample with reset on its second CALC cycle.
    push_sample($urandom(), $urandom(), $urandom(), $urandom());
    wait_busy("abort");
    @(posedge clock);
    #1;
    reset = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    repeat (2) @(posedge clock);
    #1;
    reset    = 1'b0;
    m_primed = 1'b0;
    rd_addr  = 2'd1;
    n_done   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (sample_done) n_done++;
    end
    check_eq("abort_no_done", 32'(n_done), 32'h0);
    check_eq("abort_rd_zero", rd_data, 32'h0);
    check_eq("abort_sat_zero", 32'(sat_flags), 32'h0);

    push_sample(32'd1, 32'd2, 32'd3, 32'd4);
    expect_sample("reprime", 1'b0);
    push_sample(32'd11, 32'd0, 32'd3, 32'h00FF_FFFF + 32'd4);
    expect_sample("post", 1'b1);

    // Drop enable mid-sample; the sample must still complete.
    push_sample(32'd1011, 32'd5, 32'd3, 32'h0100_0004);
    wait_busy("en_low");
    enable = 1'b0;
    expect_sample("en_low", 1'b1);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (sample_done) n_done++;
    end
    check_eq("en_low_quiet", 32'(n_done), 32'h0);

    push_sample($urandom(), $urandom(), $urandom(), $urandom());
    @(posedge clock);
    #1;
    enable = 1'b1;
    c0     = cyc;
    expect_sample("en_rise", 1'b0);
    check_eq("en_rise_latency", 32'(last_done - c0), PERIOD + N_CH + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_sample_scheduler.md
# speed_sample_scheduler

Time-multiplexed speed estimator for all wheel and odometer encoders. An internal sample timer snapshots every encoder count on the same clock edge. One shared subtract/abs/saturate unit then converts each channel's count delta into a sign-magnitude speed word, one channel per cycle. Results land in a double-buffered register bank that the SPI/readout logic reads by address; a bank update is atomic and signalled by a one-cycle pulse.

## Interface
- N_CH, 4, number of encoder channels (≥1)
- CNT_W, 32, encoder count width
- PERIOD, 50000, clocks between samples; must satisfy PERIOD ≥ N_CH+4
- clock  in  1  system clock; one clock domain, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  sample timer run; low holds timer at 0, in-flight sample still completes
- count_flat  in  N_CH*CNT_W  signed encoder counts, channel k at bits [k*CNT_W +: CNT_W]
- rd_addr  in  $clog2(N_CH) (min 1)  channel select for readout
- rd_data  out  32  registered speed word of published bank[rd_addr]
- sat_flags  out  N_CH  per-channel saturation flag of published bank
- sample_done  out  1  one-cycle pulse: published bank just updated
- busy  out  1  high while snapshot/calculation in progress

## Operation
- Speed word format: {7'b0, sign, mag[23:0]}; sign=1 when delta negative.
- Delta = snap[k] − prev[k] in CNT_W-bit modular arithmetic, so counter wrap gives the true small delta.
- mag = |delta|; if |delta| > 2^24−1 (including delta = −2^(CNT_W−1)), mag = 0xFFFFFF and sat flag set.
- FSM states: IDLE, CALC, DONE.
  - IDLE: timer increments while enable=1. At timer == PERIOD−1, timer → 0, all counts latch into snap[], old snap[] → prev[], ch → 0, go to CALC.
  - CALC: staging[ch] ← shaped word of ch, stage_sat[ch] ← flag, ch++. After ch == N_CH−1, go to DONE.
  - DONE: published ← staging, sat_flags ← stage_sat, sample_done = 1, go to IDLE.
- The timer keeps counting in CALC/DONE. The PERIOD constraint guarantees no tick can arrive while busy. A tick in a non-IDLE state is a design error; assert it in simulation.
- Priming: the first snapshot after reset has no valid prev[]. Its staged words are forced to 0 with sat flags 0, and the bank is still published with sample_done. The primed flag is set afterwards.
- enable falling mid-sample: the sample completes normally; the timer is then held at 0. When enable rises, the first tick occurs PERIOD cycles later.
- rd_addr ≥ N_CH returns 0.

## Timing
- Reset values: rd_data 0, sat_flags 0, sample_done 0, busy 0, timer 0, state IDLE, published/staging/snap/prev 0, primed 0.
- Snapshot edge E0 is the edge at which timer == PERIOD−1 in IDLE.
- busy is high from E0+1 through the DONE cycle (N_CH+1 cycles).
- sample_done and the new published bank are visible after edge E0+N_CH+1, for one cycle.
- rd_data latency: 1 clock from rd_addr. If rd_addr is held, rd_data reflects a new bank 1 cycle after sample_done.
- Reset mid-CALC or in DONE: no sample_done, bank zeroed, primed cleared. The next sample is a priming sample.
- Tick-to-tick spacing is exactly PERIOD clocks while enable=1.

## Structure
- Package speed_pkg: SPEED_MAG_W=24, SPEED_PAD_W=7, SPEED_MAG_MAX, state_t enum {IDLE, CALC, DONE}, pack function building the 32-bit word.
- Sub-module speed_abs_sat: combinational; inputs cur and prev; outputs sign, mag[23:0], sat. It is instantiated once and shared across channels via a ch-indexed mux.

## Test plan
- Reset held 5 cycles with random counts → rd_data 0, sat_flags 0, busy 0, no sample_done.
- N_CH=4, PERIOD=16: priming sample, then ch0 count 100 → 350 → rd_data[ch0] = 0x000000FA, sat 0, sample_done exactly 16 cycles after the previous one.
- ch1 1000 → 400 → rd_data = 0x01000258. ch2 constant → 0x00000000.
- ch3 delta 0x01000000 → rd_data = 0x01FFFFFF if the delta is negative, 0x00FFFFFF if positive; sat_flags[3] = 1. Next sample with delta 5 clears the flag.
- Wrap: ch0 0x7FFFFFF0 → 0x80000010 → 0x00000020. 0xFFFFFFFE → 0x00000003 → 0x00000005.
- reset asserted on the second CALC cycle → no sample_done. The next sample publishes all zeros (priming). The following sample returns correct deltas.
